// File: rtl/lcd_fill_rect_pkg.sv
// Shared definitions for the rectangle-fill word source: panel defaults,
// command bytes, dc flags and the FSM state type.
package lcd_fill_rect_pkg;

    localparam int unsigned H_RES_DEF     = 240;
    localparam int unsigned V_RES_DEF     = 320;
    localparam logic [7:0]  CMD_CASET_DEF = 8'h2A;
    localparam logic [7:0]  CMD_RASET_DEF = 8'h2B;
    localparam logic [7:0]  CMD_RAMWR_DEF = 8'h2C;
    localparam logic        DC_CMD        = 1'b0;
    localparam logic        DC_DAT        = 1'b1;
    localparam logic [3:0]  HDR_LAST      = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } fill_state_t;

    function automatic logic [8:0] addr_hi(input logic [8:0] v);
        return {DC_DAT, 7'b0, v[8]};
    endfunction

    function automatic logic [8:0] addr_lo(input logic [8:0] v);
        return {DC_DAT, v[7:0]};
    endfunction

endpackage

// File: rtl/lcd_fill_rect.sv
// Fills an LCD window with one RGB565 colour: CASET/RASET/RAMWR header, then
// hi/lo pixel bytes, one word per en_write_fill/wr_done handshake.
module lcd_fill_rect
    import lcd_fill_rect_pkg::*;
#(
    parameter int unsigned H_RES     = H_RES_DEF,
    parameter int unsigned V_RES     = V_RES_DEF,
    parameter logic [7:0]  CMD_CASET = CMD_CASET_DEF,
    parameter logic [7:0]  CMD_RASET = CMD_RASET_DEF,
    parameter logic [7:0]  CMD_RAMWR = CMD_RAMWR_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [8:0]  x0,
    input  logic [8:0]  y0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y1,
    input  logic [15:0] color,
    input  logic        wr_done,
    output logic [8:0]  fill_data,
    output logic        en_write_fill,
    output logic        busy,
    output logic        fill_done,
    output logic        fill_err
);

    fill_state_t state, state_n;
    logic [8:0]  x0_r, y0_r, x1_r, y1_r, x0_n, y0_n, x1_n, y1_n;
    logic [15:0] color_r, color_n;
    logic [3:0]  k_r, k_n;
    logic        pix_r, pix_n, hi_r, hi_n;
    logic [16:0] cnt_r, cnt_n;
    logic [8:0]  data_n;
    logic        en_n, busy_n, done_n, err_n;
    logic        valid;
    logic [8:0]  span_x, span_y;
    logic [16:0] area;

    assign valid  = (x0 <= x1) && (y0 <= y1) && (32'(x1) < H_RES) && (32'(y1) < V_RES);
    assign span_x = x1 - x0 + 9'd1;
    assign span_y = y1 - y0 + 9'd1;
    assign area   = 17'(span_x) * 17'(span_y);

    always_comb begin
        state_n = state;
        x0_n    = x0_r;
        y0_n    = y0_r;
        x1_n    = x1_r;
        y1_n    = y1_r;
        color_n = color_r;
        k_n     = k_r;
        pix_n   = pix_r;
        hi_n    = hi_r;
        cnt_n   = cnt_r;
        data_n  = fill_data;
        en_n    = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (valid) begin
                        x0_n    = x0;
                        y0_n    = y0;
                        x1_n    = x1;
                        y1_n    = y1;
                        color_n = color;
                        k_n     = '0;
                        pix_n   = 1'b0;
                        hi_n    = 1'b1;
                        cnt_n   = area;
                        busy_n  = 1'b1;
                        state_n = ST_ISSUE;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_ISSUE: state_n = ST_WAIT;
            ST_WAIT: begin
                if (wr_done) begin
                    if (!pix_r) begin
                        if (k_r == HDR_LAST) pix_n = 1'b1;
                        else                 k_n   = k_r + 4'd1;
                        state_n = ST_ISSUE;
                    end else if (hi_r) begin
                        hi_n    = 1'b0;
                        state_n = ST_ISSUE;
                    end else begin
                        cnt_n = cnt_r - 17'd1;
                        hi_n  = 1'b1;
                        if (cnt_n == '0) begin
                            state_n = ST_DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ST_ISSUE;
                        end
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        // Word selection uses the next-cycle indices so the registered word and
        // en_write_fill line up with the ISSUE cycle.
        if (state_n == ST_ISSUE) begin
            en_n = 1'b1;
            if (pix_n) begin
                data_n = {DC_DAT, hi_n ? color_n[15:8] : color_n[7:0]};
            end else begin
                case (k_n)
                    4'd0:    data_n = {DC_CMD, CMD_CASET};
                    4'd1:    data_n = addr_hi(x0_n);
                    4'd2:    data_n = addr_lo(x0_n);
                    4'd3:    data_n = addr_hi(x1_n);
                    4'd4:    data_n = addr_lo(x1_n);
                    4'd5:    data_n = {DC_CMD, CMD_RASET};
                    4'd6:    data_n = addr_hi(y0_n);
                    4'd7:    data_n = addr_lo(y0_n);
                    4'd8:    data_n = addr_hi(y1_n);
                    4'd9:    data_n = addr_lo(y1_n);
                    default: data_n = {DC_CMD, CMD_RAMWR};
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            x0_r          <= '0;
            y0_r          <= '0;
            x1_r          <= '0;
            y1_r          <= '0;
            color_r       <= '0;
            k_r           <= '0;
            pix_r         <= 1'b0;
            hi_r          <= 1'b0;
            cnt_r         <= '0;
            fill_data     <= '0;
            en_write_fill <= 1'b0;
            busy          <= 1'b0;
            fill_done     <= 1'b0;
            fill_err      <= 1'b0;
        end else begin
            state         <= state_n;
            x0_r          <= x0_n;
            y0_r          <= y0_n;
            x1_r          <= x1_n;
            y1_r          <= y1_n;
            color_r       <= color_n;
            k_r           <= k_n;
            pix_r         <= pix_n;
            hi_r          <= hi_n;
            cnt_r         <= cnt_n;
            fill_data     <= data_n;
            en_write_fill <= en_n;
            busy          <= busy_n;
            fill_done     <= done_n;
            fill_err      <= err_n;
        end
    end

endmodule

// File: tb/tb_lcd_fill_rect.sv
// Bench for lcd_fill_rect: an lcd_write stand-in answers each request after a
// delay, and a word-list model of the fill is checked against every issued word.
module tb_lcd_fill_rect;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [15:0] color = '0;
    logic        wr_done_resp = 1'b0, spur_idle = 1'b0, spur_issue = 1'b0;
    logic        wr_done;
    logic [8:0]  fill_data;
    logic        en_write_fill, busy, fill_done, fill_err;

    assign wr_done = wr_done_resp | spur_idle | spur_issue;

    lcd_fill_rect #(.H_RES(240), .V_RES(320)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .wr_done(wr_done),
        .fill_data(fill_data), .en_write_fill(en_write_fill), .busy(busy),
        .fill_done(fill_done), .fill_err(fill_err)
    );

    always #10 sys_clk = ~sys_clk;

    int          n_cmp = 0, n_bad = 0;
    int          n_words = 0, n_resp = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  last_word = '0;
    bit          exp_active = 1'b0, fast = 1'b1, spur_mode = 1'b0;

    logic [8:0] lit2 [0:12] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02B,
                                9'h100, 9'h100, 9'h100, 9'h100, 9'h02C, 9'h1F8, 9'h100};
    logic [8:0] lit3 [0:18] = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10B, 9'h02B,
                                9'h100, 9'h114, 9'h100, 9'h115, 9'h02C,
                                9'h107, 9'h1E0, 9'h107, 9'h1E0, 9'h107, 9'h1E0, 9'h107, 9'h1E0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected word list of one fill, straight from the rectangle and colour.
    task automatic model_push(input int ax0, input int ay0, input int ax1, input int ay1, input int col);
        int n;
        exp_q.push_back(9'h02A);
        exp_q.push_back(9'(256 + ax0 / 256));
        exp_q.push_back(9'(256 + ax0 % 256));
        exp_q.push_back(9'(256 + ax1 / 256));
        exp_q.push_back(9'(256 + ax1 % 256));
        exp_q.push_back(9'h02B);
        exp_q.push_back(9'(256 + ay0 / 256));
        exp_q.push_back(9'(256 + ay0 % 256));
        exp_q.push_back(9'(256 + ay1 / 256));
        exp_q.push_back(9'(256 + ay1 % 256));
        exp_q.push_back(9'h02C);
        n = (ax1 - ax0 + 1) * (ay1 - ay0 + 1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(9'(256 + col / 256));
            exp_q.push_back(9'(256 + col % 256));
        end
    endtask

    // lcd_write stand-in
    initial begin
        int d;
        forever begin
            @(negedge sys_clk);
            wr_done_resp = 1'b0;
            if (en_write_fill && !sys_rst) begin
                d = fast ? 1 : int'($urandom_range(1, 40));
                if (spur_mode) begin
                    spur_issue = 1'b1;
                    @(negedge sys_clk);
                    spur_issue = 1'b0;
                    d = d - 1;
                end
                repeat (d) @(negedge sys_clk);
                wr_done_resp = 1'b1;
                n_resp++;
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        logic [8:0] w;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!sys_rst) begin
                if (en_write_fill) begin
                    n_words++;
                    chk("busy_with_en", 32'(busy), 1);
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 32'(exp_q.size()), 1);
                    end else begin
                        w = exp_q.pop_front();
                        chk("word", 32'(fill_data), 32'(w));
                    end
                    last_word = fill_data;
                end else if (busy) begin
                    chk("hold_word", 32'(fill_data), 32'(last_word));
                end
                if (fill_done) begin
                    chk("done_expected", 32'(exp_active), 1);
                    chk("done_queue_empty", 32'(exp_q.size()), 0);
                    chk("done_after_wr_done", 32'(wr_done_resp), 1);
                    chk("done_busy_low", 32'(busy), 0);
                end
            end
        end
    end

    task automatic drive_start(input int ax0, input int ay0, input int ax1, input int ay1, input int col);
        @(negedge sys_clk);
        x0 = 9'(ax0); y0 = 9'(ay0); x1 = 9'(ax1); y1 = 9'(ay1); color = 16'(col);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        x0 = 9'($urandom); y0 = 9'($urandom); x1 = 9'($urandom); y1 = 9'($urandom);
        color = 16'($urandom);
    endtask

    task automatic run_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int col, input int budget, input bit disturb);
        int cyc, busy_low, err_cnt, w0, r0, w1;
        exp_active = 1'b1;
        model_push(ax0, ay0, ax1, ay1, col);
        w0 = n_words;
        r0 = n_resp;
        drive_start(ax0, ay0, ax1, ay1, col);
        chk("first_en", 32'(en_write_fill), 1);
        chk("busy_on_accept", 32'(busy), 1);
        cyc = 0; busy_low = 0; err_cnt = 0;
        while (!fill_done && cyc < budget) begin
            @(negedge sys_clk);
            cyc++;
            if (disturb && cyc == 4) begin
                x0 = 9'd1; y0 = 9'd1; x1 = 9'd2; y1 = 9'd2; start = 1'b1;
            end
            if (disturb && cyc == 5) start = 1'b0;
            if (!fill_done && !busy) busy_low++;
            if (fill_err) err_cnt++;
        end
        chk("done_seen", 32'(fill_done), 1);
        chk("busy_held", 32'(busy_low), 0);
        chk("no_err_during_fill", 32'(err_cnt), 0);
        chk("word_total", 32'(n_words - w0), 32'(11 + 2 * (ax1 - ax0 + 1) * (ay1 - ay0 + 1)));
        chk("wr_done_total", 32'(n_resp - r0), 32'(n_words - w0));
        if (disturb) begin
            x0 = '0; y0 = '0; x1 = '0; y1 = '0; start = 1'b1;
            @(negedge sys_clk);
            start = 1'b0;
            chk("start_in_done_busy", 32'(busy), 0);
            chk("start_in_done_en", 32'(en_write_fill), 0);
            w1 = n_words;
            repeat (10) @(negedge sys_clk);
            chk("start_in_done_words", 32'(n_words - w1), 0);
        end
        exp_active = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic run_reject(input int ax0, input int ay0, input int ax1, input int ay1);
        int w0;
        w0 = n_words;
        drive_start(ax0, ay0, ax1, ay1, 16'h1234);
        chk("err_pulse", 32'(fill_err), 1);
        chk("err_busy", 32'(busy), 0);
        @(negedge sys_clk);
        chk("err_one_cycle", 32'(fill_err), 0);
        repeat (20) @(negedge sys_clk);
        chk("err_no_words", 32'(n_words - w0), 0);
        chk("err_busy_after", 32'(busy), 0);
    endtask

    initial begin
        int cyc, w0;
        @(negedge sys_clk);
        chk("rst_fill_data", 32'(fill_data), 0);
        chk("rst_en", 32'(en_write_fill), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(fill_done), 0);
        chk("rst_err", 32'(fill_err), 0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Reset in the middle of the pixel phase
        fast = 1'b1;
        exp_active = 1'b1;
        model_push(0, 0, 9, 9, 16'h1234);
        drive_start(0, 0, 9, 9, 16'h1234);
        cyc = 0;
        while (n_words < 40 && cyc < 2000) begin
            @(negedge sys_clk);
            cyc++;
        end
        chk("reset_reached_pixels", 32'(n_words >= 40), 1);
        sys_rst = 1'b1;
        #1;
        chk("abort_fill_data", 32'(fill_data), 0);
        chk("abort_en", 32'(en_write_fill), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(fill_done), 0);
        exp_q.delete();
        exp_active = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        w0 = n_words;
        repeat (60) @(negedge sys_clk);
        chk("abort_no_words", 32'(n_words - w0), 0);

        // Single pixel at the origin, words pinned by hand
        model_push(0, 0, 0, 0, 16'hF800);
        for (int i = 0; i < 13; i++) chk("model_pin_px", 32'(exp_q[i]), 32'(lit2[i]));
        exp_q.delete();
        fast = 1'b0;
        run_fill(0, 0, 0, 0, 16'hF800, 2000, 1'b0);

        // 2x2 window
        model_push(10, 20, 11, 21, 16'h07E0);
        for (int i = 0; i < 19; i++) chk("model_pin_2x2", 32'(exp_q[i]), 32'(lit3[i]));
        exp_q.delete();
        run_fill(10, 20, 11, 21, 16'h07E0, 2000, 1'b0);

        // Full-width band touching the bottom edge, and the far corner pixel
        fast = 1'b1;
        run_fill(0, 280, 239, 319, 16'h0000, 40000, 1'b0);
        chk("band_last_word", 32'(last_word), 32'h100);
        run_fill(239, 319, 239, 319, 16'hABCD, 200, 1'b0);
        chk("corner_last_word", 32'(last_word), 32'h1CD);

        // Rejected windows
        run_reject(0, 0, 240, 0);
        run_reject(5, 0, 4, 0);
        run_reject(0, 0, 0, 320);
        run_reject(0, 5, 0, 4);

        // Spurious wr_done in IDLE and ISSUE, restart while busy and in DONE
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            spur_idle = 1'b1;
            @(negedge sys_clk);
            spur_idle = 1'b0;
        end
        chk("spur_idle_busy", 32'(busy), 0);
        fast = 1'b0;
        spur_mode = 1'b1;
        run_fill(10, 20, 11, 21, 16'h07E0, 2000, 1'b1);
        spur_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
